// File: rtl/err_pwr_meter_pkg.sv
// Shared types and defaults for the windowed squared-error power meter.
package err_pwr_meter_pkg;

  localparam int LFSR_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/err_pwr_meter_sq_chan.sv
// One error channel: S1 register holding the truncated square of a signed 1sX sample.
module err_sq_chan #(
  parameter int ERR_W = 18
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_en,
  input  logic signed [ERR_W-1:0] i_err,
  output logic        [ERR_W-1:0] o_sq_p1
);

  // Keep product bits [2W-2:W-1]; a square never sets the sign bit, and -2^(W-1) maps to 2^(W-1).
  function automatic logic [ERR_W-1:0] sq_trunc(input logic signed [ERR_W-1:0] e);
    logic signed [2*ERR_W-1:0] p;
    p = e * e;
    return ERR_W'(p >> (ERR_W - 1));
  endfunction

  logic [ERR_W-1:0] r_sq_p1;

  // ---- S1: square and truncate ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sq_p1 <= '0;
    end else if (i_en) begin
      r_sq_p1 <= sq_trunc(i_err);
    end
  end

  assign o_sq_p1 = r_sq_p1;

endmodule

// File: rtl/err_pwr_meter.sv
// Multi-channel windowed squared-error power meter with valid/ready result port.
module err_pwr_meter
  import err_pwr_meter_pkg::*;
#(
  parameter int  ERR_W    = 18,
  parameter int  NCH      = 2,
  parameter int  LOG2_WIN = LFSR_LEN,
  localparam int CH_BITS  = (NCH > 1) ? $clog2(NCH) : 0,
  localparam int SUM_W    = ERR_W + CH_BITS,
  localparam int ACC_W    = SUM_W + LOG2_WIN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_en,
  input  logic [NCH*ERR_W-1:0] err_in,
  input  logic                 err_valid,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic                 hold,
  input  logic                 clear_ovr,
  output logic [ACC_W-1:0]     res_sum,
  output logic [SUM_W-1:0]     res_mean,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 overrun,
  output logic                 busy
);

  state_t              r_state;
  logic                r_mode_cont;
  logic [LOG2_WIN-1:0] r_in_cnt;
  logic                r_vld_p1, r_last_p1, r_vld_p2, r_last_p2;
  logic [ERR_W-1:0]    w_sq_p1 [NCH];
  logic [SUM_W-1:0]    w_sum, r_sum_p2;
  logic [ACC_W-1:0]    r_acc, w_acc_next;
  logic [ACC_W-1:0]    r_res_sum;
  logic [SUM_W-1:0]    r_res_mean;
  logic                r_res_valid, r_overrun;
  logic                w_accept, w_stop, w_last_in, w_load;

  assign w_stop     = clk_en & stop & (r_state != ST_IDLE);
  assign w_accept   = clk_en & err_valid & (r_state == ST_RUN) & ~hold;
  assign w_last_in  = &r_in_cnt;
  assign w_load     = clk_en & r_vld_p2 & r_last_p2 & ~w_stop;
  assign w_acc_next = r_acc + ACC_W'(r_sum_p2);

  // ---- S1: per-channel squares ----
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    err_sq_chan #(.ERR_W(ERR_W)) u_sq (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (clk_en),
      .i_err   (err_in[g*ERR_W +: ERR_W]),
      .o_sq_p1 (w_sq_p1[g])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sum = w_sum + SUM_W'(w_sq_p1[i]);
    end
  end

  // ---- S2: channel sum ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum_p2 <= '0;
    end else if (clk_en) begin
      r_sum_p2 <= w_sum;
    end
  end

  // ---- Control: FSM, sample counter, valid/last tags, accumulator ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_mode_cont <= 1'b0;
      r_in_cnt    <= '0;
      r_vld_p1    <= 1'b0;
      r_last_p1   <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_last_p2   <= 1'b0;
      r_acc       <= '0;
    end else if (clk_en) begin
      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_in_cnt  <= '0;
        r_acc     <= '0;
        r_vld_p1  <= 1'b0;
        r_last_p1 <= 1'b0;
        r_vld_p2  <= 1'b0;
        r_last_p2 <= 1'b0;
      end else begin
        r_vld_p1  <= w_accept;
        r_last_p1 <= w_accept & w_last_in;
        r_vld_p2  <= r_vld_p1;
        r_last_p2 <= r_last_p1;
        if (w_accept) r_in_cnt <= r_in_cnt + LOG2_WIN'(1);
        if (r_vld_p2) r_acc <= r_last_p2 ? '0 : w_acc_next;
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state     <= ST_RUN;
              r_mode_cont <= continuous;
              r_in_cnt    <= '0;
              r_acc       <= '0;
            end
          end
          ST_RUN:   if (w_accept && w_last_in && !r_mode_cont) r_state <= ST_DRAIN;
          ST_DRAIN: if (r_vld_p2 && r_last_p2) r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---- Result register: handshake and overrun run every clk ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res_sum   <= '0;
      r_res_mean  <= '0;
      r_res_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_res_sum   <= w_acc_next;
        r_res_mean  <= SUM_W'(w_acc_next >> LOG2_WIN);
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (w_load && r_res_valid && !res_ready) begin
        r_overrun <= 1'b1;
      end else if (clear_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign res_sum   = r_res_sum;
  assign res_mean  = r_res_mean;
  assign res_valid = r_res_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_err_pwr_meter.sv
// Randomized self-checking bench for err_pwr_meter against a plain-arithmetic window model.
module tb_err_pwr_meter;

  localparam int ERR_W    = 18;
  localparam int NCH      = 2;
  localparam int LOG2_WIN = 2;
  localparam int SUM_W    = ERR_W + 1;
  localparam int ACC_W    = SUM_W + LOG2_WIN;
  localparam int WIN      = 1 << LOG2_WIN;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 clk_en = 1'b1;
  logic [NCH*ERR_W-1:0] err_in = '0;
  logic                 err_valid = 1'b0;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic                 continuous = 1'b0;
  logic                 hold = 1'b0;
  logic                 clear_ovr = 1'b0;
  logic [ACC_W-1:0]     res_sum;
  logic [SUM_W-1:0]     res_mean;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic                 overrun;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  err_pwr_meter #(.ERR_W(ERR_W), .NCH(NCH), .LOG2_WIN(LOG2_WIN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .err_in     (err_in),
    .err_valid  (err_valid),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .hold       (hold),
    .clear_ovr  (clear_ovr),
    .res_sum    (res_sum),
    .res_mean   (res_mean),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: truncated square of a 1sX sample, floor(e^2 / 2^(ERR_W-1)).
  function automatic longint sqv(input int e);
    return (longint'(e) * longint'(e)) / (longint'(1) << (ERR_W - 1));
  endfunction

  function automatic int rnd_err();
    return int'($urandom_range(262143, 0)) - 131072;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int a, input int b, input bit v, input bit h);
    err_in    = {b[ERR_W-1:0], a[ERR_W-1:0]};
    err_valid = v;
    hold      = h;
    tick();
  endtask

  task automatic begin_win(input bit cont);
    clk_en = 1'b1; start = 1'b1; continuous = cont; err_valid = 1'b0; hold = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic wait_res(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (res_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (res_sum !== '0)     begin errors++; $display("FAIL reset_sum: got %0d expected 0", res_sum); end
    checks++; if (res_mean !== '0)    begin errors++; $display("FAIL reset_mean: got %0d expected 0", res_mean); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", res_valid); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %0b expected 0", busy); end
  endtask

  task automatic test_basic();
    begin_win(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %0b expected 1", busy); end
    for (int i = 0; i < WIN; i++) put(65536, 65536, 1'b1, 1'b0);
    err_valid = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b expected 0", res_valid); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL basic_busy_drain: got %0b expected 1", busy); end
    tick();
    checks++; if (res_valid !== 1'b1)           begin errors++; $display("FAIL basic_valid: got %0b expected 1", res_valid); end
    checks++; if (busy !== 1'b0)                begin errors++; $display("FAIL basic_busy_fall: got %0b expected 0", busy); end
    checks++; if (res_sum !== ACC_W'(262144))   begin errors++; $display("FAIL basic_sum: got %0d expected 262144", res_sum); end
    checks++; if (res_mean !== SUM_W'(65536))   begin errors++; $display("FAIL basic_mean: got %0d expected 65536", res_mean); end
    ack();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake: got %0b expected 0", res_valid); end
  endtask

  task automatic test_most_neg();
    bit got;
    begin_win(1'b0);
    for (int i = 0; i < WIN; i++) put(-131072, -131072, 1'b1, 1'b0);
    err_valid = 1'b0;
    wait_res(10, got);
    checks++; if (got !== 1'b1)                  begin errors++; $display("FAIL neg_timeout: got %0b expected 1", got); end
    checks++; if (res_sum !== ACC_W'(1048576))   begin errors++; $display("FAIL neg_sum: got %0d expected 1048576", res_sum); end
    checks++; if (res_mean !== SUM_W'(262144))   begin errors++; $display("FAIL neg_mean: got %0d expected 262144", res_mean); end
    ack();
  endtask

  task automatic test_random_single();
    bit got;
    for (int it = 0; it < 4; it++) begin
      longint exp_sum = 0;
      int cnt = 0;
      begin_win(1'b0);
      for (int g = 0; g < 60 && cnt < WIN; g++) begin
        int a = rnd_err();
        int b = rnd_err();
        bit v = ($urandom_range(3, 0) != 0);
        bit h = ($urandom_range(3, 0) == 0);
        put(a, b, v, h);
        if (v && !h) begin
          exp_sum += sqv(a) + sqv(b);
          cnt++;
        end
      end
      err_valid = 1'b0; hold = 1'b0;
      wait_res(10, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rand_timeout: got %0b expected 1", got); end
      checks++; if (res_sum !== ACC_W'(exp_sum)) begin errors++; $display("FAIL rand_sum: got %0d expected %0d", res_sum, exp_sum); end
      checks++; if (res_mean !== SUM_W'(exp_sum >> LOG2_WIN)) begin errors++; $display("FAIL rand_mean: got %0d expected %0d", res_mean, exp_sum >> LOG2_WIN); end
      ack();
    end
  endtask

  task automatic test_hold();
    bit got;
    int a = rnd_err();
    longint exp_sum = 2 * WIN * sqv(a);
    begin_win(1'b0);
    put(a, a, 1'b1, 1'b0);
    put(a, a, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) put(-131072, -131072, 1'b1, 1'b1);
    put(a, a, 1'b1, 1'b0);
    put(a, a, 1'b1, 1'b0);
    err_valid = 1'b0;
    wait_res(10, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL hold_timeout: got %0b expected 1", got); end
    checks++; if (res_sum !== ACC_W'(exp_sum)) begin errors++; $display("FAIL hold_sum: got %0d expected %0d", res_sum, exp_sum); end
    ack();
  endtask

  task automatic test_stop();
    bit got;
    int a = rnd_err();
    longint exp_sum = 2 * WIN * sqv(a);
    begin_win(1'b0);
    put(-131072, -131072, 1'b1, 1'b0);
    put(-131072, -131072, 1'b1, 1'b0);
    err_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0b expected 0", busy); end
    repeat (4) tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stop_no_result: got %0b expected 0", res_valid); end
    begin_win(1'b0);
    for (int i = 0; i < WIN; i++) put(a, a, 1'b1, 1'b0);
    err_valid = 1'b0;
    wait_res(10, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL stop_restart_timeout: got %0b expected 1", got); end
    checks++; if (res_sum !== ACC_W'(exp_sum)) begin errors++; $display("FAIL stop_restart_sum: got %0d expected %0d", res_sum, exp_sum); end
    ack();
  endtask

  task automatic test_continuous();
    longint expq[$];
    longint wacc = 0;
    int cnt = 0;
    int nres = 0;
    res_ready = 1'b1;
    begin_win(1'b1);
    for (int i = 0; i < 2 * WIN + 6; i++) begin
      if (i < 2 * WIN) begin
        int a = (i == 0) ? 65536 : rnd_err();
        int b = rnd_err();
        put(a, b, 1'b1, 1'b0);
        wacc += sqv(a) + sqv(b);
        cnt++;
        if (cnt == WIN) begin
          expq.push_back(wacc);
          wacc = 0;
          cnt = 0;
        end
      end else begin
        put(0, 0, 1'b0, 1'b0);
      end
      if (res_valid === 1'b1) begin
        longint e = (expq.size() > 0) ? expq[0] : -1;
        checks++;
        if (res_sum !== ACC_W'(e) || e < 0) begin errors++; $display("FAIL cont_sum: got %0d expected %0d", res_sum, e); end
        if (expq.size() > 0) void'(expq.pop_front());
        nres++;
      end
    end
    checks++; if (nres != 2)          begin errors++; $display("FAIL cont_count: got %0d expected 2", nres); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL cont_overrun: got %0b expected 0", overrun); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL cont_busy: got %0b expected 1", busy); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    res_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_overrun();
    res_ready = 1'b0;
    begin_win(1'b1);
    for (int i = 0; i < WIN; i++) put(65536, 65536, 1'b1, 1'b0);
    err_valid = 1'b0;
    tick(); tick();
    checks++; if (res_sum !== ACC_W'(262144)) begin errors++; $display("FAIL ovr_first_sum: got %0d expected 262144", res_sum); end
    checks++; if (overrun !== 1'b0)           begin errors++; $display("FAIL ovr_first_flag: got %0b expected 0", overrun); end
    for (int i = 0; i < WIN; i++) put(-131072, -131072, 1'b1, 1'b0);
    err_valid = 1'b0;
    tick(); tick();
    checks++; if (res_sum !== ACC_W'(1048576)) begin errors++; $display("FAIL ovr_second_sum: got %0d expected 1048576", res_sum); end
    checks++; if (overrun !== 1'b1)            begin errors++; $display("FAIL ovr_set: got %0b expected 1", overrun); end
    checks++; if (res_valid !== 1'b1)          begin errors++; $display("FAIL ovr_valid: got %0b expected 1", res_valid); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0b expected 1", overrun); end
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %0b expected 0", overrun); end
    ack();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %0b expected 0", res_valid); end
  endtask

  task automatic test_clk_en();
    bit got;
    int va[WIN];
    int vb[WIN];
    int idx = 0;
    longint exp_sum = 0;
    for (int i = 0; i < WIN; i++) begin
      va[i] = rnd_err();
      vb[i] = rnd_err();
      exp_sum += sqv(va[i]) + sqv(vb[i]);
    end
    begin_win(1'b0);
    for (int i = 0; i < WIN; i++) put(va[i], vb[i], 1'b1, 1'b0);
    err_valid = 1'b0;
    wait_res(10, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL gate_ref_timeout: got %0b expected 1", got); end
    checks++; if (res_sum !== ACC_W'(exp_sum)) begin errors++; $display("FAIL gate_ref_sum: got %0d expected %0d", res_sum, exp_sum); end
    ack();
    begin_win(1'b0);
    for (int g = 0; g < 80 && idx < WIN; g++) begin
      bit en = ($urandom_range(1, 0) == 1);
      clk_en = en;
      put(va[idx], vb[idx], 1'b1, 1'b0);
      if (en) idx++;
    end
    err_valid = 1'b0;
    checks++; if (idx != WIN) begin errors++; $display("FAIL gate_feed_timeout: got %0d expected %0d", idx, WIN); end
    got = 1'b0;
    for (int g = 0; g < 80; g++) begin
      clk_en = ($urandom_range(1, 0) == 1);
      tick();
      if (res_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    clk_en = 1'b1;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL gate_timeout: got %0b expected 1", got); end
    checks++; if (res_sum !== ACC_W'(exp_sum)) begin errors++; $display("FAIL gate_sum: got %0d expected %0d", res_sum, exp_sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy: got %0b expected 0", busy); end
    ack();
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0;
    begin_win(1'b1);
    for (int i = 0; i < WIN; i++) put(65536, 65536, 1'b1, 1'b0);
    err_valid = 1'b0;
    tick(); tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %0b expected 1", res_valid); end
    put(65536, 65536, 1'b1, 1'b0);
    put(65536, 65536, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({res_sum, res_mean} !== '0) begin errors++; $display("FAIL areset_data: got %0d/%0d expected 0/0", res_sum, res_mean); end
    checks++; if ({res_valid, overrun} !== 2'b00) begin errors++; $display("FAIL areset_flags: got %0b%0b expected 00", res_valid, overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %0b expected 0", busy); end
    err_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL areset_after: got %0b%0b expected 00", res_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_most_neg();
    test_random_single();
    test_hold();
    test_stop();
    test_continuous();
    test_overrun();
    test_clk_en();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
